// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache sequencing controller.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MEM_REQ = 3'd2,
    S_REFILL  = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  localparam int BYTE_OFF_W         = 2;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int WORD_OFF_W         = $clog2(DEF_WORDS_PER_LINE);

  // Clears the byte and word offset bits, leaving the line-aligned address.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int word_off_w);
    logic [63:0] mask;
    mask = ~((64'd1 << (word_off_w + BYTE_OFF_W)) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Read-only sequencing controller for a direct-mapped cache: lookup, line refill
// from memory on a miss, single-cycle response pulse, saturating hit/miss stats.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_hit,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_fill_we,
  output logic [DATA_W-1:0] cache_fill_data,
  output logic              cache_fill_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int                WOFF_W    = $clog2(WORDS_PER_LINE);
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(3'd4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [WOFF_W-1:0] beat_q, beat_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic [WOFF_W-1:0] word_off_s;
  logic [ADDR_W-1:0] line_base_s;
  logic              fill_we_s;
  logic              hit_inc_s;
  logic              miss_inc_s;

  assign word_off_s  = addr_q[BYTE_OFF_W +: WOFF_W];
  assign line_base_s = ADDR_W'(line_base(64'(addr_q), WOFF_W));

  // Fill strobe and data track the memory beat in the same cycle so the write lands at cache_addr.
  assign fill_we_s       = (state_q == S_REFILL) && mem_rvalid;
  assign cache_fill_we   = fill_we_s;
  assign cache_fill_last = fill_we_s && (beat_q == LAST_BEAT);
  assign cache_fill_data = fill_we_s ? mem_rdata : {DATA_W{1'b0}};

  assign hit_inc_s  = (state_q == S_LOOKUP) && cache_hit;
  assign miss_inc_s = (state_q == S_LOOKUP) && !cache_hit;

  // Next-state and next-output computation for the request sequencer.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cache_addr_d    = cache_addr_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_valid_d = mem_req_valid_q;
    beat_d          = beat_q;
    req_ready_d     = req_ready_q;
    resp_valid_d    = 1'b0;
    resp_hit_d      = resp_hit_q;
    resp_data_d     = resp_data_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (cpu_req_valid) begin
          addr_d       = cpu_addr;
          cache_addr_d = cpu_addr;
          req_ready_d  = 1'b0;
          state_d      = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          resp_data_d  = cache_rdata;
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESPOND;
        end else begin
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = line_base_s;
          state_d         = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          beat_d          = {WOFF_W{1'b0}};
          cache_addr_d    = line_base_s;
          state_d         = S_REFILL;
        end else begin
          state_d = S_MEM_REQ;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          if (beat_q == word_off_s) begin
            resp_data_d = mem_rdata;
          end else begin
            resp_data_d = resp_data_q;
          end
          if (beat_q == LAST_BEAT) begin
            resp_hit_d   = 1'b0;
            resp_valid_d = 1'b1;
            cache_addr_d = addr_q;
            state_d      = S_RESPOND;
          end else begin
            beat_d       = beat_q + WOFF_W'(1'b1);
            cache_addr_d = cache_addr_q + WORD_STEP;
          end
        end else begin
          state_d = S_REFILL;
        end
      end
      S_RESPOND: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        mem_req_valid_d = 1'b0;
        req_ready_d     = 1'b1;
        state_d         = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= {ADDR_W{1'b0}};
      cache_addr_q    <= {ADDR_W{1'b0}};
      mem_req_addr_q  <= {ADDR_W{1'b0}};
      mem_req_valid_q <= 1'b0;
      beat_q          <= {WOFF_W{1'b0}};
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= {DATA_W{1'b0}};
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cache_addr_q    <= cache_addr_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_valid_q <= mem_req_valid_d;
      beat_q          <= beat_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign cpu_req_ready  = req_ready_q;
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_data  = resp_data_q;
  assign cpu_resp_hit   = resp_hit_q;
  assign cache_addr     = cache_addr_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = mem_req_addr_q;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc_s),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc_s),
    .count (miss_count)
  );

endmodule
